difftest_commit_sequencer: RTL
==============================

// Module: difftest_commit_sequencer
// PURPOSE
//  Sits between the ROB commit lanes and the single-lane difftest instruction-commit and trap probes.
//  Captures up to LANES commits per cycle into a ring buffer and replays them one per cycle in program order.
//  Each replayed commit is tagged with a sequence index.
//  A trap request is held until every older commit has been replayed. One trap pulse is then emitted and the block halts.
// PARAMETERS
//  LANES   4   commit lanes sampled per cycle (1..8)
//  DEPTH   16  buffer entries; power of 2, >= 2*LANES
// PORTS
//  clock          in   1         sole clock, rising edge
//  reset_n        in   1         synchronous, active-low reset
//  in_valid       in   LANES     per-lane commit valid; any lane pattern is legal
//  in_pc          in   LANES*64  lane i at [64i+63:64i]
//  in_instr       in   LANES*32  lane i at [32i+31:32i]
//  in_rfwen       in   LANES     integer regfile write enable per lane
//  in_wdest       in   LANES*8   destination register per lane
//  in_ready       out  1         block accepts the current commit group this cycle
//  trap_valid     in   1         trap request (single-cycle pulse)
//  trap_code      in   3         trap code; 0 means good trap
//  trap_pc        in   64        pc of the trapping instruction
//  out_valid      out  1         replayed commit valid
//  out_pc         out  64        replayed commit pc
//  out_instr      out  32        replayed commit instruction
//  out_rfwen      out  1         replayed commit regfile write enable
//  out_wdest      out  8         replayed commit destination register
//  out_index      out  8         sequence number of the replayed commit, mod 256
//  out_trap_valid out  1         one-cycle trap pulse
//  out_trap_code  out  3         trap code, held after the pulse
//  out_trap_pc    out  64        trap pc, held after the pulse
//  out_instr_cnt  out  64        total commits emitted on out_valid
//  halted         out  1         high from the trap pulse until reset
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge) clears the following: buffer pointers, count, FSM=RUN, out_index, out_instr_cnt, trap registers.
//    All outputs read 0 the following cycle; in_ready reads 1 the following cycle.
//    Reset mid-drain discards buffered commits and any pending trap.
//  - in_ready = (state==RUN) && (DEPTH-count >= LANES). It is combinational from registered state only.
//  - Accept: when in_ready is high, the valid lanes are compacted in ascending lane order.
//    They are written at wr_ptr..wr_ptr+popcount-1 (mod DEPTH). Lanes whose in_valid is 0 are dropped.
//    Commits offered while in_ready=0 are ignored; the upstream must hold them.
//  - Replay: if count>0, pop the head each cycle and drive out_* registered. out_valid is a one-cycle pulse per entry.
//    Minimum latency from accept edge to out_valid is 1 cycle. Commits are never back-pressured on the output.
//  - out_index and out_instr_cnt increment by 1 per out_valid. out_index wraps 255->0.
//  - count' = count + accepted - popped. A push and a pop in the same cycle are legal.
//  - Pointers are log2(DEPTH) bits and wrap naturally.
//  - FSM:
//      RUN:   trap_valid -> latch code/pc, go to DRAIN.
//             A group accepted in the same cycle as trap_valid is older than the trap and is replayed first.
//      DRAIN: in_ready=0; further trap_valid is ignored (the first trap wins). When count==0 and no pop is in flight, go to TRAP.
//      TRAP:  out_trap_valid=1 for exactly one cycle, then go to HALT.
//             The trap pulse is strictly after the last out_valid; they never occur in the same cycle.
//      HALT:  in_ready=0, halted=1; all inputs are ignored until reset.
//  - Trap arriving with an empty buffer: DRAIN lasts 1 cycle. The pulse appears 2 cycles after trap_valid.
// STRUCTURE
//  - Package difftest_seq_pkg:
//      commit_entry_t {pc[63:0], instr[31:0], rfwen, wdest[7:0]}
//      seq_state_e {RUN, DRAIN, TRAP, HALT}
//      TRAP_GOOD = 3'd0
//  - Sub-module difftest_commit_fifo: multi-write (LANES), single-read ring buffer.
//    It handles lane compaction with a prefix-popcount and exposes count.
//    The top level holds the FSM, counters and trap registers.
// TESTING
//  1. Reset, then lane0 commit pc=0x8000_0000 -> out_valid 1 cycle later, out_index=0, out_instr_cnt=1.
//  2. in_valid=4'b1010, pcs 0x10/0x20/0x30/0x40 -> out pcs 0x20 then 0x40 on consecutive cycles, indices 0,1.
//  3. 5 full groups of 4 with DEPTH=16 -> in_ready drops once count>12.
//     All 20 commits are emitted in order; none are lost or duplicated.
//  4. Trap code=0 pc=0x1234 in the same cycle as a 3-lane group while 5 are buffered
//     -> 8 out_valid pulses, then out_trap_valid on the next cycle, halted=1, out_instr_cnt=8.
//  5. Second trap_valid (code=1) during DRAIN -> ignored; out_trap_code=0.
//     Trap with an empty buffer -> pulse exactly 2 cycles later.
//  6. reset_n=0 during DRAIN with 6 buffered -> no out_valid or trap afterwards, in_ready=1.
//     256 single commits -> out_index wraps 255->0 and out_instr_cnt=256.

Source files
------------

// File: rtl/difftest_commit_sequencer_pkg.sv
// Purpose : shared types for the difftest commit sequencer (commit entry, FSM states, trap codes).
// Latency : n/a (types only).
// Backpressure: n/a.
package difftest_seq_pkg;

    // One buffered commit as replayed to the single-lane difftest probe.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        rfwen;
        logic [7:0]  wdest;
    } commit_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TRAP  = 2'd2,
        HALT  = 2'd3
    } seq_state_e;

    localparam logic [2:0] TRAP_GOOD = 3'd0;

endpackage

// File: rtl/difftest_commit_sequencer_if.sv
// Purpose : bundles the ROB commit lanes, trap request and the replayed difftest probe signals.
// Latency : n/a (wiring only).
// Backpressure: in_ready flows back to the commit producer; the replay side has none.
// Ports   : master = commit/trap producer (and probe consumer), slave = the sequencer.
interface difftest_commit_sequencer_if #(
    parameter int LANES = 4
);
    logic [LANES-1:0]    in_valid;
    logic [LANES*64-1:0] in_pc;
    logic [LANES*32-1:0] in_instr;
    logic [LANES-1:0]    in_rfwen;
    logic [LANES*8-1:0]  in_wdest;
    logic                in_ready;
    logic                trap_valid;
    logic [2:0]          trap_code;
    logic [63:0]         trap_pc;
    logic                out_valid;
    logic [63:0]         out_pc;
    logic [31:0]         out_instr;
    logic                out_rfwen;
    logic [7:0]          out_wdest;
    logic [7:0]          out_index;
    logic                out_trap_valid;
    logic [2:0]          out_trap_code;
    logic [63:0]         out_trap_pc;
    logic [63:0]         out_instr_cnt;
    logic                halted;

    modport master (
        output in_valid, in_pc, in_instr, in_rfwen, in_wdest, trap_valid, trap_code, trap_pc,
        input  in_ready, out_valid, out_pc, out_instr, out_rfwen, out_wdest, out_index,
               out_trap_valid, out_trap_code, out_trap_pc, out_instr_cnt, halted
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_rfwen, in_wdest, trap_valid, trap_code, trap_pc,
        output in_ready, out_valid, out_pc, out_instr, out_rfwen, out_wdest, out_index,
               out_trap_valid, out_trap_code, out_trap_pc, out_instr_cnt, halted
    );
endinterface

// File: rtl/difftest_commit_sequencer_fifo.sv
// Purpose : LANES-wide write, single read ring buffer; valid lanes are compacted in lane order.
// Latency : an entry written at an edge is readable at rd_dat right after that edge.
// Backpressure: none internally; the caller only asserts wr_en when LANES free slots exist.
// Ports   : wr_en/wr_lane_vld/wr_lane_dat write side, rd_en/rd_dat read side, count occupancy.
module difftest_commit_fifo
    import difftest_seq_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DEPTH = 16,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [LANES-1:0] wr_lane_vld,
    input  commit_entry_t    wr_lane_dat [LANES],
    input  logic             rd_en,
    output commit_entry_t    rd_dat,
    output logic [CW-1:0]    count
);
    commit_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] lane_addr [LANES];
    logic [CW-1:0] push_cnt;
    logic          do_rd;

    // Prefix popcount: each valid lane lands at wr_ptr + (number of valid lanes below it).
    always_comb begin : prefix_sum
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_addr[i] = wr_ptr + acc[PW-1:0];
            acc          = acc + CW'(wr_lane_vld[i]);
        end
        push_cnt = wr_en ? acc : '0;
    end

    assign do_rd  = rd_en && (count != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt[PW-1:0];
            rd_ptr <= rd_ptr + PW'(do_rd);
            count  <= count + push_cnt - CW'(do_rd);
        end
    end

    // Storage carries no reset; pointers and count define what is live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && wr_lane_vld[i]) begin
                mem[lane_addr[i]] <= wr_lane_dat[i];
            end
        end
    end
endmodule

// File: rtl/difftest_commit_sequencer.sv
// Purpose : buffers up to LANES ROB commits per cycle and replays them one per cycle in order, then one trap pulse.
// Latency : 1 cycle from accept edge to out_valid; trap pulse follows the last older commit by 1 cycle.
// Backpressure: in_ready drops when fewer than LANES slots are free or once a trap is seen; output never stalls.
// Ports   : clock, reset_n (sync, active-low), bus = commit lanes + trap request in, difftest probes out.
module difftest_commit_sequencer
    import difftest_seq_pkg::*;
#(
    parameter int LANES = 4,   // 1..8
    parameter int DEPTH = 16   // power of 2, >= 2*LANES
) (
    input  logic                         clock,
    input  logic                         reset_n,
    difftest_commit_sequencer_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_e    state_q, state_d;
    commit_entry_t lane_dat [LANES];
    commit_entry_t head_dat;
    commit_entry_t out_q;
    logic [CW-1:0] count;
    logic          accept;
    logic          pop;
    logic          run_st;
    logic          trap_pulse;
    logic          halted_st;
    logic          out_vld_q;
    logic [7:0]    out_index_q;
    logic [63:0]   instr_cnt_q;
    logic [2:0]    trap_code_q;
    logic [63:0]   trap_pc_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_dat[i].pc    = bus.in_pc[64*i +: 64];
            lane_dat[i].instr = bus.in_instr[32*i +: 32];
            lane_dat[i].rfwen = bus.in_rfwen[i];
            lane_dat[i].wdest = bus.in_wdest[8*i +: 8];
        end
    end

    // Only registered state feeds in_ready, so it never depends on this cycle's inputs.
    assign accept = run_st && (count <= CW'(DEPTH - LANES));
    assign pop    = (count != '0);

    difftest_commit_fifo #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en       (accept),
        .wr_lane_vld (bus.in_valid),
        .wr_lane_dat (lane_dat),
        .rd_en       (pop),
        .rd_dat      (head_dat),
        .count       (count)
    );

    always_comb begin
        state_d    = state_q;
        run_st     = 1'b0;
        trap_pulse = 1'b0;
        halted_st  = 1'b0;
        unique case (state_q)
            RUN: begin
                run_st = 1'b1;
                if (bus.trap_valid) state_d = DRAIN;
            end
            // count==0 here means the final pop already happened last edge, so the
            // pulse lands the cycle after the last out_valid, never alongside it.
            DRAIN: if (count == '0) state_d = TRAP;
            TRAP: begin
                trap_pulse = 1'b1;
                halted_st  = 1'b1;
                state_d    = HALT;
            end
            HALT: halted_st = 1'b1;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= RUN;
            out_vld_q   <= 1'b0;
            out_q       <= '0;
            out_index_q <= '0;
            instr_cnt_q <= '0;
            trap_code_q <= TRAP_GOOD;
            trap_pc_q   <= '0;
        end else begin
            state_q   <= state_d;
            out_vld_q <= pop;
            // First trap wins: later requests arrive outside RUN and are ignored.
            if (run_st && bus.trap_valid) begin
                trap_code_q <= bus.trap_code;
                trap_pc_q   <= bus.trap_pc;
            end
            if (pop) begin
                out_q       <= head_dat;
                out_index_q <= instr_cnt_q[7:0];
                instr_cnt_q <= instr_cnt_q + 64'd1;
            end
        end
    end

    assign bus.in_ready       = accept;
    assign bus.out_valid      = out_vld_q;
    assign bus.out_pc         = out_q.pc;
    assign bus.out_instr      = out_q.instr;
    assign bus.out_rfwen      = out_q.rfwen;
    assign bus.out_wdest      = out_q.wdest;
    assign bus.out_index      = out_index_q;
    assign bus.out_trap_valid = trap_pulse;
    assign bus.out_trap_code  = trap_code_q;
    assign bus.out_trap_pc    = trap_pc_q;
    assign bus.out_instr_cnt  = instr_cnt_q;
    assign bus.halted         = halted_st;
endmodule
